// File: rtl/aqua_sensor_classifier_if.sv
// Sample/condition bundle between the sensor front end and the classifier.
// Latency: none (wires only).
// Backpressure: none; samples are fire-and-forget strobes, condition code is level.
// Ports: sample_valid, do_level, temp, ph (toward classifier);
//        I1, I0, cond_changed, sensor_fault (from classifier).
interface aqua_sensor_classifier_if #(
  parameter int W = 8
);
  logic         sample_valid;
  logic [W-1:0] do_level;
  logic [W-1:0] temp;
  logic [W-1:0] ph;
  logic         I1;
  logic         I0;
  logic         cond_changed;
  logic         sensor_fault;

  // master: sensor front end / test driver
  modport master (
    output sample_valid, do_level, temp, ph,
    input  I1, I0, cond_changed, sensor_fault
  );

  // slave: the classifier
  modport slave (
    input  sample_valid, do_level, temp, ph,
    output I1, I0, cond_changed, sensor_fault
  );
endinterface

// File: rtl/aqua_sensor_classifier.sv
// Classifies water-quality samples into normal/warning/critical with persistence filter and sample watchdog.
// Latency: condition code registered on the edge that samples the qualifying input, visible next cycle.
// Backpressure: none; every sample_valid strobe is consumed, the block never stalls its source.
// Ports: clk, rst_n (async active-low); bus.slave carries sample_valid/do_level/temp/ph in and
//        I1/I0 (condition code), cond_changed (1-cycle pulse), sensor_fault out.
module aqua_sensor_classifier #(
  parameter int W            = 8,
  parameter int DO_WARN_LO   = 60,
  parameter int DO_CRIT_LO   = 40,
  parameter int TEMP_WARN_LO = 24,
  parameter int TEMP_WARN_HI = 30,
  parameter int TEMP_CRIT_LO = 20,
  parameter int TEMP_CRIT_HI = 34,
  parameter int PH_WARN_LO   = 65,
  parameter int PH_WARN_HI   = 85,
  parameter int PH_CRIT_LO   = 55,
  parameter int PH_CRIT_HI   = 95,
  parameter int ESC_CNT      = 2,
  parameter int DEESC_CNT    = 4,
  parameter int TIMEOUT      = 1000
) (
  input logic                      clk,
  input logic                      rst_n,
  aqua_sensor_classifier_if.slave  bus
);

  typedef enum logic [1:0] {
    COND_NORMAL = 2'b00,
    COND_WARN   = 2'b01,
    COND_CRIT   = 2'b10,
    COND_FAULT  = 2'b11
  } cond_t;

  // Thresholds resized to the sample width so the compares are width-clean.
  localparam logic [W-1:0] DO_WL = W'(DO_WARN_LO);
  localparam logic [W-1:0] DO_CL = W'(DO_CRIT_LO);
  localparam logic [W-1:0] T_WL  = W'(TEMP_WARN_LO);
  localparam logic [W-1:0] T_WH  = W'(TEMP_WARN_HI);
  localparam logic [W-1:0] T_CL  = W'(TEMP_CRIT_LO);
  localparam logic [W-1:0] T_CH  = W'(TEMP_CRIT_HI);
  localparam logic [W-1:0] PH_WL = W'(PH_WARN_LO);
  localparam logic [W-1:0] PH_WH = W'(PH_WARN_HI);
  localparam logic [W-1:0] PH_CL = W'(PH_CRIT_LO);
  localparam logic [W-1:0] PH_CH = W'(PH_CRIT_HI);

  localparam int CMAX = (ESC_CNT > DEESC_CNT) ? ESC_CNT : DEESC_CNT;
  localparam int CW   = $clog2(CMAX + 1);
  localparam logic [CW-1:0] ESC_LAST   = CW'(ESC_CNT - 1);
  localparam logic [CW-1:0] DEESC_LAST = CW'(DEESC_CNT - 1);

  localparam int WW = $clog2(TIMEOUT + 1);
  localparam logic [WW-1:0] WD_MAX  = WW'(TIMEOUT);
  localparam logic [WW-1:0] WD_LAST = WW'(TIMEOUT - 1);

  cond_t          cond;
  cond_t          raw;
  logic           fault;
  logic           changed;
  logic [CW-1:0]  esc_cnt;
  logic [CW-1:0]  deesc_cnt;
  logic [WW-1:0]  wd_cnt;

  logic is_crit;
  logic is_warn;

  // Raw class of the current sample; only meaningful while sample_valid is high.
  always_comb begin
    is_crit = (bus.do_level < DO_CL) ||
              (bus.temp < T_CL) || (bus.temp > T_CH) ||
              (bus.ph < PH_CL)  || (bus.ph > PH_CH);
    is_warn = (bus.do_level < DO_WL) ||
              (bus.temp < T_WL) || (bus.temp > T_WH) ||
              (bus.ph < PH_WL)  || (bus.ph > PH_WH);
    raw = COND_NORMAL;
    if (is_crit) begin
      raw = COND_CRIT;
    end else if (is_warn) begin
      raw = COND_WARN;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cond      <= COND_NORMAL;
      fault     <= 1'b0;
      changed   <= 1'b0;
      esc_cnt   <= '0;
      deesc_cnt <= '0;
      wd_cnt    <= '0;
    end else begin
      changed <= 1'b0;
      if (bus.sample_valid) begin
        // A sample always feeds the watchdog, even on the would-be timeout cycle.
        wd_cnt <= '0;
        if (fault) begin
          // Leaving fault takes the sample's class at once, no persistence.
          cond      <= raw;
          fault     <= 1'b0;
          esc_cnt   <= '0;
          deesc_cnt <= '0;
          changed   <= (raw != cond);
        end else if (raw == cond) begin
          esc_cnt   <= '0;
          deesc_cnt <= '0;
        end else if (raw > cond) begin
          deesc_cnt <= '0;
          if (esc_cnt == ESC_LAST) begin
            cond    <= raw;
            esc_cnt <= '0;
            changed <= 1'b1;
          end else begin
            esc_cnt <= esc_cnt + CW'(1);
          end
        end else begin
          esc_cnt <= '0;
          if (deesc_cnt == DEESC_LAST) begin
            cond      <= raw;
            deesc_cnt <= '0;
            changed   <= 1'b1;
          end else begin
            deesc_cnt <= deesc_cnt + CW'(1);
          end
        end
      end else begin
        if (wd_cnt != WD_MAX) begin
          wd_cnt <= wd_cnt + WW'(1);
        end
        // Fault is entered on the edge where the idle count reaches TIMEOUT.
        if (!fault && (wd_cnt == WD_LAST)) begin
          cond      <= COND_FAULT;
          fault     <= 1'b1;
          esc_cnt   <= '0;
          deesc_cnt <= '0;
          changed   <= (cond != COND_FAULT);
        end
      end
    end
  end

  assign bus.I1           = cond[1];
  assign bus.I0           = cond[0];
  assign bus.cond_changed = changed;
  assign bus.sensor_fault = fault;

endmodule

// File: tb/tb_aqua_sensor_classifier.sv
// Self-checking bench for aqua_sensor_classifier: directed scenarios plus random samples,
// expected {I1,I0,cond_changed,sensor_fault} per cycle queued by a reference model and
// compared by an independent monitor.
module tb_aqua_sensor_classifier;

  localparam int ESC     = 2;
  localparam int DEESC   = 4;
  localparam int TMO     = 1000;

  logic clk;
  logic rst_n;

  aqua_sensor_classifier_if #(.W(8)) bus ();

  aqua_sensor_classifier dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total;
  int bad;
  int prints;
  logic [3:0] exp_q[$];

  // Reference model state: current level 0..3, fault flag, streak lengths, idle cycles.
  int m_cond;
  int m_fault;
  int m_up;
  int m_down;
  int m_idle;

  function automatic int classify(input int d, input int t, input int p);
    if (d < 40 || t < 20 || t > 34 || p < 55 || p > 95) return 2;
    if (d < 60 || t < 24 || t > 30 || p < 65 || p > 85) return 1;
    return 0;
  endfunction

  task automatic model_reset();
    m_cond  = 0;
    m_fault = 0;
    m_up    = 0;
    m_down  = 0;
    m_idle  = 0;
  endtask

  task automatic model_step(input bit v, input int d, input int t, input int p,
                            output logic [3:0] e);
    int old;
    int r;
    old = m_cond;
    if (v) begin
      m_idle = 0;
      r = classify(d, t, p);
      if (m_fault != 0) begin
        m_cond = r; m_fault = 0; m_up = 0; m_down = 0;
      end else if (r == m_cond) begin
        m_up = 0; m_down = 0;
      end else if (r > m_cond) begin
        m_down = 0;
        m_up++;
        if (m_up >= ESC) begin m_cond = r; m_up = 0; end
      end else begin
        m_up = 0;
        m_down++;
        if (m_down >= DEESC) begin m_cond = r; m_down = 0; end
      end
    end else if (m_fault == 0) begin
      m_idle++;
      if (m_idle >= TMO) begin
        m_fault = 1; m_cond = 3; m_up = 0; m_down = 0;
      end
    end
    e = {2'(m_cond), (m_cond != old), (m_fault != 0)};
  endtask

  task automatic check(input string name, input logic [3:0] got, input logic [3:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      if (prints < 40) begin
        prints++;
        $display("FAIL %s t=%0t got {I1I0,chg,flt}=%b required=%b", name, $time, got, exp);
      end
    end
  endtask

  // Monitor: one expected entry per clock edge, compared just after the edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        logic [3:0] e;
        e = exp_q.pop_front();
        check("cycle", {bus.I1, bus.I0, bus.cond_changed, bus.sensor_fault}, e);
      end
    end
  end

  task automatic cyc(input bit v, input int d, input int t, input int p);
    logic [3:0] e;
    @(negedge clk);
    rst_n            = 1'b1;
    bus.sample_valid = v;
    bus.do_level     = d[7:0];
    bus.temp         = t[7:0];
    bus.ph           = p[7:0];
    model_step(v, d, t, p, e);
    exp_q.push_back(e);
  endtask

  task automatic samp(input int d, input int t, input int p);
    cyc(1'b1, d, t, p);
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(1'b0, 0, 0, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    bus.sample_valid = 1'b0;
    rst_n = 1'b0;
    model_reset();
    #1;
    check("async_reset", {bus.I1, bus.I0, bus.cond_changed, bus.sensor_fault}, 4'b0000);
    exp_q.push_back(4'b0000);
  endtask

  initial begin
    total  = 0;
    bad    = 0;
    prints = 0;
    rst_n  = 1'b0;
    bus.sample_valid = 1'b0;
    bus.do_level = '0;
    bus.temp     = '0;
    bus.ph       = '0;
    model_reset();

    do_reset();

    // Steady normal samples every 10 cycles.
    repeat (10) begin
      samp(80, 27, 75);
      idle(9);
    end

    // Isolated warning does not escalate; two in a row do.
    samp(80, 27, 75);
    samp(50, 27, 75);
    samp(80, 27, 75);
    samp(50, 27, 75);
    samp(50, 27, 75);

    // Warning -> critical, critical -> normal after four normals.
    samp(80, 36, 75);
    samp(80, 36, 75);
    repeat (4) samp(80, 27, 75);

    // Back to critical, then an interrupted de-escalation.
    samp(80, 36, 75);
    samp(80, 36, 75);
    samp(80, 27, 75);
    samp(80, 27, 75);
    samp(80, 36, 75);
    samp(80, 27, 75);
    samp(80, 36, 75);

    // Mixed less-severe run commits to the last sample's class (warning).
    samp(50, 27, 75);
    samp(80, 27, 75);
    samp(80, 27, 75);
    samp(50, 27, 75);

    // Watchdog timeout, then immediate fault exit on a warning sample.
    idle(TMO);
    samp(80, 27, 60);

    // Sample arriving exactly on the timeout cycle prevents the fault.
    idle(TMO - 1);
    samp(80, 27, 75);
    samp(50, 27, 75);

    // Reset with a pending escalation count in warning state.
    samp(50, 27, 75);
    samp(50, 27, 75);
    samp(30, 27, 75);
    do_reset();
    samp(50, 27, 75);
    samp(80, 27, 75);

    // Random samples clustered around the thresholds.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(499, 0) == 0) begin
        do_reset();
      end else if ($urandom_range(99, 0) < 40) begin
        samp($urandom_range(90, 30), $urandom_range(40, 15), $urandom_range(100, 50));
      end else begin
        idle(1);
      end
    end

    // Idle bursts straddling the timeout.
    for (int k = 0; k < 3; k++) begin
      samp($urandom_range(90, 30), $urandom_range(40, 15), $urandom_range(100, 50));
      idle($urandom_range(TMO + 3, TMO - 3));
      samp($urandom_range(90, 30), $urandom_range(40, 15), $urandom_range(100, 50));
      idle(3);
    end

    idle(2);
    for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge clk);
    #3;
    if (exp_q.size() != 0) begin
      bad++;
      total++;
      $display("FAIL drain pending=%0d required=0", exp_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/aqua_sensor_classifier.md
Name: aqua_sensor_classifier

Overview:
- Upstream stage of the aquaculture control FSM.
- Takes periodic water-quality samples (dissolved oxygen, temperature, pH) and classifies each as normal, warning or critical.
- Filters the classification with escalation/de-escalation persistence and a sample watchdog.
- Drives the 2-bit condition code {I1,I0} consumed by the FSM: 00 normal, 01 warning, 10 critical, 11 sensor fault (FSM treats as critical).

Parameters:
- W, 8, width of each sensor sample (unsigned).
- DO_WARN_LO, 60, dissolved oxygen below this is warning (units 0.1 mg/L).
- DO_CRIT_LO, 40, dissolved oxygen below this is critical.
- TEMP_WARN_LO, 24, temperature below this is warning (deg C).
- TEMP_WARN_HI, 30, temperature above this is warning.
- TEMP_CRIT_LO, 20, temperature below this is critical.
- TEMP_CRIT_HI, 34, temperature above this is critical.
- PH_WARN_LO, 65, pH x10 below this is warning.
- PH_WARN_HI, 85, pH x10 above this is warning.
- PH_CRIT_LO, 55, pH x10 below this is critical.
- PH_CRIT_HI, 95, pH x10 above this is critical.
- ESC_CNT, 2, consecutive more-severe samples required to escalate (>=1).
- DEESC_CNT, 4, consecutive less-severe samples required to de-escalate (>=1).
- TIMEOUT, 1000, cycles without sample_valid before fault (>=2).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- sample_valid  in  1  one-cycle strobe; do_level/temp/ph valid this cycle.
- do_level  in  W  dissolved oxygen sample.
- temp  in  W  temperature sample.
- ph  in  W  pH x10 sample.
- I1  out  1  condition code MSB (registered).
- I0  out  1  condition code LSB (registered).
- cond_changed  out  1  one-cycle pulse when {I1,I0} changes.
- sensor_fault  out  1  high while in watchdog fault (equals I1&I0).

Behaviour:
- Reset (async, rst_n=0): {I1,I0}=00, cond_changed=0, sensor_fault=0, esc/deesc counters=0, watchdog=0.
- Raw classification (combinational, only used when sample_valid=1), all comparisons strict:
  - critical(2) if do_level<DO_CRIT_LO, or temp<TEMP_CRIT_LO, or temp>TEMP_CRIT_HI, or ph<PH_CRIT_LO, or ph>PH_CRIT_HI.
  - else warning(1) if do_level<DO_WARN_LO, or temp outside [TEMP_WARN_LO,TEMP_WARN_HI], or ph outside [PH_WARN_LO,PH_WARN_HI].
  - else normal(0).
- Severity order: 00 < 01 < 10 < 11.
- Filter, evaluated on each edge with sample_valid=1 while not in fault:
  - raw==cond: clear both counters.
  - raw>cond: deesc counter cleared; esc counter increments; when it reaches ESC_CNT, cond<=raw and both counters clear.
  - raw<cond: esc counter cleared; deesc counter increments; when it reaches DEESC_CNT, cond<=raw and both counters clear.
  - Commit value is the raw class of the committing sample. Intermediate samples only need to be on the same side of cond.
  - Latency: cond updates on the same edge that samples the qualifying input; visible the next cycle.
- Watchdog:
  - Counter clears on every sample_valid and otherwise increments, saturating.
  - When it reaches TIMEOUT: cond<=11, sensor_fault<=1, counters clear.
  - sample_valid in that same cycle wins: no fault, the sample is processed normally.
- Fault exit: the first sample_valid in fault sets cond<=raw immediately (no persistence), sensor_fault<=0, counters clear.
- cond_changed: 1 for exactly one cycle after any edge where cond's new value differs from its old value, including fault entry and exit; otherwise 0.
- With sample_valid=0 and no timeout, all state holds except the watchdog.
- Reset mid-operation aborts pending counts; outputs return to reset values immediately.

Test Plan:
- Reset then do=80,temp=27,ph=75 valid every 10 cycles -> {I1,I0}=00 throughout, cond_changed never pulses.
- From 00, do=50 on two consecutive samples (ESC_CNT=2) -> 01 after the second sample edge, cond_changed one pulse; a single do=50 sample between normals -> stays 00.
- From 01, temp=36 x2 -> 10; then 4 normal samples -> 00 only after the 4th; normal,normal,critical,normal sequence -> stays 10 (counter cleared).
- From 10, samples warning,normal,normal,warning (all less severe, DEESC_CNT=4) -> commits to 01 on the 4th.
- No sample_valid for 1000 cycles -> {I1,I0}=11, sensor_fault=1 at cycle 1000; next sample with ph=60 -> 01 immediately, fault=0, two cond_changed pulses total. Sample_valid exactly on cycle 1000 -> no fault.
- Assert rst_n low while the esc counter is at 1 in state 01 -> async clear to 00; the next single warning sample does not escalate.
